// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
//   Shared definitions for the CPU bus arbiter slice:
//   - command field layout of the 71-bit inst/data/bus command word
//   - owner encoding stored in the outstanding-request queue
//   - arbiter FSM state encoding
package cpu_bus_pkg;

    // Command word: {wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]}
    localparam int CMD_W     = 71;
    localparam int WR_BIT    = 70;
    localparam int SIZE_LSB  = 68;
    localparam int WSTRB_LSB = 64;
    localparam int ADDR_LSB  = 32;
    localparam int WDATA_LSB = 0;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_owner_fifo.sv
// bus_owner_fifo
//   Records which master owns each request accepted on the shared bus, so
//   in-order responses can be steered back to the right master.
//   Ports:
//     clk_i        clock
//     reset_i      synchronous active-high reset (clears pointers and count)
//     push_i       enqueue push_owner_i
//     push_owner_i owner of the accepted request
//     pop_i        dequeue head
//     full_o       DEPTH entries outstanding
//     empty_o      no entries outstanding
//     head_o       owner of the oldest outstanding request
module bus_owner_fifo
    import cpu_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   push_i,
    input  owner_e push_owner_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output owner_e head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    owner_e             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push while full is only taken when a pop frees a slot the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_owner_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
//   Merges an instruction-side and a data-side request port onto one shared
//   split-transaction bus. Data side has fixed priority; a grant is held
//   until the bus accepts or the master withdraws. Responses return in order
//   and are steered by an owner queue of OUTSTANDING entries.
//   Ports:
//     clk, reset                     clock, synchronous active-high reset
//     inst_req/inst_cmd              instruction request in
//     inst_addr_ok/data_ok/rdata     instruction accept / response out
//     data_req/data_cmd              data request in
//     data_addr_ok/data_ok/rdata     data accept / response out
//     bus_req/bus_cmd                shared-bus request out
//     bus_addr_ok/data_ok/rdata      shared-bus accept / response in
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             inst_req,
    input  logic [CMD_W-1:0] inst_cmd,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,

    input  logic             data_req,
    input  logic [CMD_W-1:0] data_cmd,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,

    output logic             bus_req,
    output logic [CMD_W-1:0] bus_cmd,
    input  logic             bus_addr_ok,
    input  logic             bus_data_ok,
    input  logic [31:0]      bus_rdata
);

    arb_state_e state_q;
    logic       grant_inst;
    logic       grant_data;
    logic       fifo_push;
    owner_e     fifo_push_owner;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    owner_e     fifo_head;

    // Grant is live only while the owning master still requests, so a
    // withdrawn request drops bus_req in the same cycle.
    assign grant_inst = (state_q == GNT_INST) && inst_req && !reset;
    assign grant_data = (state_q == GNT_DATA) && data_req && !reset;

    assign bus_req      = grant_inst || grant_data;
    assign bus_cmd      = (state_q == GNT_DATA) ? data_cmd :
                          (state_q == GNT_INST) ? inst_cmd : '0;
    assign inst_addr_ok = grant_inst && bus_addr_ok;
    assign data_addr_ok = grant_data && bus_addr_ok;

    assign fifo_push       = inst_addr_ok || data_addr_ok;
    assign fifo_push_owner = data_addr_ok ? OWNER_DATA : OWNER_INST;

    // Responses with nothing outstanding are discarded.
    assign fifo_pop     = bus_data_ok && !fifo_empty && !reset;
    assign inst_data_ok = fifo_pop && (fifo_head == OWNER_INST);
    assign data_data_ok = fifo_pop && (fifo_head == OWNER_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_full) begin
                        if (data_req)      state_q <= GNT_DATA;
                        else if (inst_req) state_q <= GNT_INST;
                    end
                end
                GNT_INST: if (!inst_req || bus_addr_ok) state_q <= IDLE;
                GNT_DATA: if (!data_req || bus_addr_ok) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    bus_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk_i        (clk),
        .reset_i      (reset),
        .push_i       (fifo_push),
        .push_owner_i (fifo_push_owner),
        .pop_i        (fifo_pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (fifo_head)
    );

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [70:0] inst_cmd;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [70:0] data_cmd;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic [70:0] bus_cmd;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [70:0] ICMD = {1'b0, 2'b10, 4'hF, 32'h1000_0000, 32'h0000_0000};
    localparam logic [70:0] DCMD = {1'b1, 2'b10, 4'h3, 32'h2000_0004, 32'hDEAD_BEEF};

    always #5 clk = ~clk;

    cpu_bus_arbiter #(
        .OUTSTANDING (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_cmd     (inst_cmd),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_cmd     (data_cmd),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_cmd      (bus_cmd),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point, half a period away from the active edge.
    task automatic samp();
        @(negedge clk);
    endtask

    // Starting in IDLE with an empty-enough queue: one IDLE cycle, then a
    // granted cycle accepted by the bus. Returns in IDLE with requests low.
    task automatic issue(input bit is_data, input string tag);
        if (is_data) data_req = 1'b1; else inst_req = 1'b1;
        bus_addr_ok = 1'b1;
        samp();
        check({tag, "_idle_bus_req"}, 71'(bus_req), 71'(0));
        tick();
        samp();
        check({tag, "_addr_ok"}, 71'(is_data ? data_addr_ok : inst_addr_ok), 71'(1));
        check({tag, "_bus_cmd"}, bus_cmd, is_data ? DCMD : ICMD);
        tick();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        bus_addr_ok = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd, input bit exp_i, input bit exp_d, input string tag);
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        samp();
        check({tag, "_inst_data_ok"}, 71'(inst_data_ok), 71'(exp_i));
        check({tag, "_data_data_ok"}, 71'(data_data_ok), 71'(exp_d));
        if (exp_i) check({tag, "_inst_rdata"}, 71'(inst_rdata), 71'(rd));
        if (exp_d) check({tag, "_data_rdata"}, 71'(data_rdata), 71'(rd));
        tick();
        bus_data_ok = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        inst_req    = 1'b0;
        data_req    = 1'b0;
        inst_cmd    = ICMD;
        data_cmd    = DCMD;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h0;

        // Reset: everything quiet even with bus handshakes high.
        tick();
        inst_req = 1'b1;
        data_req = 1'b1;
        samp();
        check("rst_bus_req", 71'(bus_req), 71'(0));
        check("rst_inst_addr_ok", 71'(inst_addr_ok), 71'(0));
        check("rst_data_addr_ok", 71'(data_addr_ok), 71'(0));
        check("rst_inst_data_ok", 71'(inst_data_ok), 71'(0));
        check("rst_data_data_ok", 71'(data_data_ok), 71'(0));
        tick();
        reset       = 1'b0;
        bus_data_ok = 1'b0;

        // Simultaneous requests: data first, inst two cycles later.
        samp();
        check("pri_idle_bus_req", 71'(bus_req), 71'(0));
        tick();
        samp();
        check("pri_data_addr_ok", 71'(data_addr_ok), 71'(1));
        check("pri_inst_addr_ok0", 71'(inst_addr_ok), 71'(0));
        check("pri_bus_cmd_data", bus_cmd, DCMD);
        tick();
        data_req = 1'b0;
        samp();
        check("pri_gap_bus_req", 71'(bus_req), 71'(0));
        tick();
        samp();
        check("pri_inst_addr_ok", 71'(inst_addr_ok), 71'(1));
        check("pri_bus_cmd_inst", bus_cmd, ICMD);
        tick();
        inst_req    = 1'b0;
        bus_addr_ok = 1'b0;
        // Queue holds [data, inst].
        respond(32'hAAAA_0001, 1'b0, 1'b1, "pri_rsp0");
        respond(32'hAAAA_0002, 1'b1, 1'b0, "pri_rsp1");

        // Inst then data accepted; responses steered in order.
        issue(1'b0, "ord_i");
        issue(1'b1, "ord_d");
        respond(32'h1111_1111, 1'b1, 1'b0, "ord_rsp0");
        respond(32'h2222_2222, 1'b0, 1'b1, "ord_rsp1");

        // Stall in GNT_INST while data_req rises: grant held.
        inst_req = 1'b1;
        samp();
        tick();
        data_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            samp();
            check("stall_bus_req", 71'(bus_req), 71'(1));
            check("stall_bus_cmd", bus_cmd, ICMD);
            check("stall_data_addr_ok", 71'(data_addr_ok), 71'(0));
            check("stall_inst_addr_ok", 71'(inst_addr_ok), 71'(0));
            tick();
        end
        bus_addr_ok = 1'b1;
        samp();
        check("stall_inst_acc", 71'(inst_addr_ok), 71'(1));
        check("stall_data_acc0", 71'(data_addr_ok), 71'(0));
        tick();
        inst_req = 1'b0;
        samp();
        check("stall_gap_bus_req", 71'(bus_req), 71'(0));
        tick();
        samp();
        check("stall_data_acc", 71'(data_addr_ok), 71'(1));
        tick();
        data_req    = 1'b0;
        bus_addr_ok = 1'b0;
        respond(32'h3333_0000, 1'b1, 1'b0, "stall_rsp0");
        respond(32'h3333_0001, 1'b0, 1'b1, "stall_rsp1");

        // Withdrawn request: bus_req drops, nothing pushed.
        data_req = 1'b1;
        samp();
        tick();
        samp();
        check("wd_bus_req_on", 71'(bus_req), 71'(1));
        tick();
        data_req = 1'b0;
        samp();
        check("wd_bus_req_off", 71'(bus_req), 71'(0));
        tick();

        // Empty queue: response ignored (also shows the withdraw pushed nothing).
        respond(32'h5555_5555, 1'b0, 1'b0, "empty_rsp");

        // Fill the queue: inst, data, inst, data.
        issue(1'b0, "full0");
        issue(1'b1, "full1");
        issue(1'b0, "full2");
        issue(1'b1, "full3");
        data_req    = 1'b1;
        bus_addr_ok = 1'b1;
        samp();
        check("full_bus_req0", 71'(bus_req), 71'(0));
        tick();
        samp();
        check("full_bus_req1", 71'(bus_req), 71'(0));
        check("full_data_addr_ok", 71'(data_addr_ok), 71'(0));
        tick();
        // Pop one while still IDLE; the grant follows once a slot is free.
        respond(32'h4444_0000, 1'b1, 1'b0, "full_rsp0");
        samp();
        check("full_after_pop_idle", 71'(bus_req), 71'(0));
        tick();
        samp();
        check("full_regrant_bus_req", 71'(bus_req), 71'(1));
        check("full_regrant_addr_ok", 71'(data_addr_ok), 71'(1));
        tick();
        data_req    = 1'b0;
        bus_addr_ok = 1'b0;
        // Queue: [data, inst, data, data].
        respond(32'h4444_0001, 1'b0, 1'b1, "full_rsp1");
        respond(32'h4444_0002, 1'b1, 1'b0, "full_rsp2");
        respond(32'h4444_0003, 1'b0, 1'b1, "full_rsp3");
        respond(32'h4444_0004, 1'b0, 1'b1, "full_rsp4");
        respond(32'h4444_0005, 1'b0, 1'b0, "full_rsp5");

        // Reset with two outstanding: their responses are dropped.
        issue(1'b0, "mr0");
        issue(1'b1, "mr1");
        reset       = 1'b1;
        bus_data_ok = 1'b1;
        samp();
        check("mr_rst_inst_data_ok", 71'(inst_data_ok), 71'(0));
        check("mr_rst_data_data_ok", 71'(data_data_ok), 71'(0));
        tick();
        reset       = 1'b0;
        bus_data_ok = 1'b0;
        respond(32'h6666_0000, 1'b0, 1'b0, "mr_drop0");
        respond(32'h6666_0001, 1'b0, 1'b0, "mr_drop1");
        issue(1'b0, "mr_new");
        respond(32'h7777_7777, 1'b1, 1'b0, "mr_new_rsp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 4: maximum accepted-but-unanswered requests (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port inst_req  input  1  instruction-side request valid.
REQ-005 SHALL have port inst_cmd  input  71  instruction command {wr[70], size[69:68], wstrb[67:64], addr[63:32], wdata[31:0]}.
REQ-006 SHALL have port inst_addr_ok  output  1  instruction request accepted this cycle.
REQ-007 SHALL have port inst_data_ok  output  1  instruction response valid this cycle.
REQ-008 SHALL have port inst_rdata  output  32  instruction response data.
REQ-009 SHALL have port data_req  input  1  data-side request valid.
REQ-010 SHALL have port data_cmd  input  71  data command, same format as inst_cmd.
REQ-011 SHALL have port data_addr_ok  output  1  data request accepted this cycle.
REQ-012 SHALL have port data_data_ok  output  1  data response valid this cycle.
REQ-013 SHALL have port data_rdata  output  32  data response data.
REQ-014 SHALL have port bus_req  output  1  shared-port request valid.
REQ-015 SHALL have port bus_cmd  output  71  command of the granted master.
REQ-016 SHALL have port bus_addr_ok  input  1  shared-port acceptance.
REQ-017 SHALL have port bus_data_ok  input  1  shared-port response (in-order).
REQ-018 SHALL have port bus_rdata  input  32  shared-port response data.

Function
REQ-019 SHALL run FSM states IDLE, GNT_INST, GNT_DATA; bus_req=0 in IDLE.
REQ-020 SHALL in IDLE, when owner FIFO not full: data_req -> GNT_DATA, else inst_req -> GNT_INST (data has fixed priority); else stay IDLE.
REQ-021 SHALL in GNT_x drive bus_req=1, bus_cmd=x_cmd (combinational), x_addr_ok=bus_addr_ok, other master's addr_ok=0.
REQ-022 SHALL hold grant in GNT_x while bus_addr_ok=0 (no re-arbitration or preemption with a request pending on the bus).
REQ-023 SHALL on bus_addr_ok=1 in GNT_x push owner x into the owner FIFO and return to IDLE next cycle (one-cycle arbitration gap).
REQ-024 SHALL, if granted master drops x_req before acceptance, deassert bus_req that cycle and return to IDLE without pushing.
REQ-025 SHALL on bus_data_ok=1 with FIFO non-empty pop the head and assert data_ok of the head owner only, same cycle (zero latency), rdata=bus_rdata to both masters.
REQ-026 SHALL ignore bus_data_ok when FIFO empty (no master sees data_ok, FIFO unchanged).
REQ-027 SHALL allow push and pop in the same cycle; occupancy unchanged; push allowed when full only if pop same cycle is not relied upon (full blocks grant in IDLE).
REQ-028 SHALL return write responses (wr=1) through the same FIFO path; rdata then don't-care.
REQ-029 SHALL keep occupancy counter width clog2(OUTSTANDING)+1, read/write pointers wrap modulo OUTSTANDING.

Reset
REQ-030 SHALL on reset=1: FSM->IDLE, FIFO pointers and count->0; all addr_ok/data_ok and bus_req=0 that cycle.
REQ-031 SHALL drop responses for requests accepted before a mid-operation reset (FIFO empty -> REQ-026 applies).

Structure
REQ-032 SHALL place the cmd field offsets, owner encoding (0=inst, 1=data) and FSM state enum in shared package cpu_bus_pkg.
REQ-033 SHALL implement the owner queue as sub-module bus_owner_fifo (1-bit wide, depth OUTSTANDING, push/pop/full/empty/head).

Verification
REQ-034 SHALL cover simultaneous inst_req and data_req, bus_addr_ok=1 -> data granted first (data_addr_ok=1), inst granted 2 cycles later.
REQ-035 SHALL cover bus_addr_ok held 0 for 3 cycles in GNT_INST while data_req rises -> bus_cmd stays inst_cmd, no data_addr_ok until inst accepted.
REQ-036 SHALL cover inst then data accepted, bus_data_ok twice with rdata 0x11111111, 0x22222222 -> inst_data_ok with 0x11111111, then data_data_ok with 0x22222222.
REQ-037 SHALL cover 4 accepted requests, no responses -> FIFO full, further data_req gets no bus_req; one bus_data_ok -> next grant proceeds.
REQ-038 SHALL cover bus_data_ok with FIFO empty -> neither inst_data_ok nor data_data_ok asserted.
REQ-039 SHALL cover reset asserted with 2 outstanding -> after reset, bus_data_ok produces no master data_ok, new inst_req granted from IDLE.
